branch_predictor: RTL and testbench

// - Consumes the resolved branch outcome (taken flag) from the execute-stage branch comparator.
// - Predicts the next fetch PC for the fetch stage, so it is the fetch-side counterpart of branch resolution.
// - Direct-mapped BTB with one 2-bit saturating counter per entry; updated from execute.
// - Flags mispredictions in execute and supplies the corrected PC for flush/redirect.
// - Keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 114 +++++++++++
 tb/tb_branch_predictor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, execute-stage
// mispredict detection/redirect, and saturating branch statistics.
module branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pcF,
   output logic                  btbHitF,
   output logic                  predictTakenF,
   output logic [DATA_WIDTH-1:0] predictPcF,
   input  logic                  updateEnE,
   input  logic [DATA_WIDTH-1:0] pcE,
   input  logic [DATA_WIDTH-1:0] targetE,
   input  logic                  branchTakenE,
   input  logic                  predictedTakenE,
   input  logic [DATA_WIDTH-1:0] predictedPcE,
   output logic                  mispredictE,
   output logic [DATA_WIDTH-1:0] correctPcE,
   output logic [31:0]           branchCount,
   output logic [31:0]           mispredictCount
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_W   = DATA_WIDTH - INDEX_BITS - 2;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   logic                  r_valid  [ENTRIES];
   logic [TAG_W-1:0]      r_tag    [ENTRIES];
   logic [DATA_WIDTH-1:0] r_target [ENTRIES];
   logic [1:0]            r_ctr    [ENTRIES];
   logic [31:0]           r_branch_cnt;
   logic [31:0]           r_mispredict_cnt;

   logic [INDEX_BITS-1:0] w_idx_f;
   logic [TAG_W-1:0]      w_tag_f;
   logic [INDEX_BITS-1:0] w_idx_e;
   logic [TAG_W-1:0]      w_tag_e;
   logic                  w_hit_e;
   logic                  w_mispredict;

   function automatic logic [1:0] f_sat_inc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] f_sat_dec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   assign w_idx_f = pcF[INDEX_BITS+1:2];
   assign w_tag_f = pcF[DATA_WIDTH-1:INDEX_BITS+2];
   assign w_idx_e = pcE[INDEX_BITS+1:2];
   assign w_tag_e = pcE[DATA_WIDTH-1:INDEX_BITS+2];
   assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

   // Fetch-side lookup and execute-side resolve are purely combinational.
   always_comb begin
      btbHitF       = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
      predictTakenF = btbHitF && r_ctr[w_idx_f][1];
      if (predictTakenF) begin
         predictPcF = r_target[w_idx_f];
      end else begin
         predictPcF = pcF + PC_STEP;
      end
      w_mispredict = (branchTakenE != predictedTakenE) ||
                     (branchTakenE && (predictedPcE != targetE));
      if (updateEnE) begin
         mispredictE = w_mispredict;
         correctPcE  = branchTakenE ? targetE : (pcE + PC_STEP);
      end else begin
         mispredictE = 1'b0;
         correctPcE  = '0;
      end
   end

   // Table update and statistics; reset outranks any same-cycle update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
         r_branch_cnt     <= 32'd0;
         r_mispredict_cnt <= 32'd0;
      end else if (updateEnE) begin
         if (w_hit_e) begin
            r_ctr[w_idx_e] <= branchTakenE ? f_sat_inc(r_ctr[w_idx_e])
                                           : f_sat_dec(r_ctr[w_idx_e]);
            if (branchTakenE) begin
               r_target[w_idx_e] <= targetE;
            end
         end else if (branchTakenE) begin
            r_valid[w_idx_e]  <= 1'b1;
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= targetE;
            r_ctr[w_idx_e]    <= 2'b10;
         end
         if (r_branch_cnt != CNT_MAX) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
         end
         if (w_mispredict && (r_mispredict_cnt != CNT_MAX)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
         end
      end
   end

   assign branchCount     = r_branch_cnt;
   assign mispredictCount = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, resolve,
// counter hysteresis, aliasing, read-old ordering and reset behaviour.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcF;
   logic        btbHitF;
   logic        predictTakenF;
   logic [31:0] predictPcF;
   logic        updateEnE;
   logic [31:0] pcE;
   logic [31:0] targetE;
   logic        branchTakenE;
   logic        predictedTakenE;
   logic [31:0] predictedPcE;
   logic        mispredictE;
   logic [31:0] correctPcE;
   logic [31:0] branchCount;
   logic [31:0] mispredictCount;

   int checks   = 0;
   int failures = 0;

   branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .pcF             (pcF),
      .btbHitF         (btbHitF),
      .predictTakenF   (predictTakenF),
      .predictPcF      (predictPcF),
      .updateEnE       (updateEnE),
      .pcE             (pcE),
      .targetE         (targetE),
      .branchTakenE    (branchTakenE),
      .predictedTakenE (predictedTakenE),
      .predictedPcE    (predictedPcE),
      .mispredictE     (mispredictE),
      .correctPcE      (correctPcE),
      .branchCount     (branchCount),
      .mispredictCount (mispredictCount)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_update(input logic en, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic tk, input logic ptk, input logic [31:0] ppc);
      updateEnE       = en;
      pcE             = pc;
      targetE         = tgt;
      branchTakenE    = tk;
      predictedTakenE = ptk;
      predictedPcE    = ppc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pcF = 32'h0000_0100;
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (btbHitF !== 1'b0 || predictTakenF !== 1'b0 || predictPcF !== 32'h0000_0104) begin
         failures++;
         $display("FAIL cold_lookup got hit=%b tk=%b pc=%h exp hit=0 tk=0 pc=00000104",
                  btbHitF, predictTakenF, predictPcF);
      end
      checks++;
      if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
         failures++;
         $display("FAIL reset_counts got b=%0d m=%0d exp 0 0", branchCount, mispredictCount);
      end
      checks++;
      if (mispredictE !== 1'b0 || correctPcE !== 32'h0) begin
         failures++;
         $display("FAIL idle_resolve got mis=%b cpc=%h exp 0 0", mispredictE, correctPcE);
      end
   endtask

   task automatic test_first_taken();
      pcF = 32'h0000_0100;
      set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0104);
      #1;
      checks++;
      if (mispredictE !== 1'b1 || correctPcE !== 32'h0000_0080) begin
         failures++;
         $display("FAIL first_resolve got mis=%b cpc=%h exp 1 00000080", mispredictE, correctPcE);
      end
      checks++;
      if (btbHitF !== 1'b0) begin
         failures++;
         $display("FAIL first_read_old got hit=%b exp 0", btbHitF);
      end
      tick();
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (btbHitF !== 1'b1 || predictTakenF !== 1'b1 || predictPcF !== 32'h0000_0080) begin
         failures++;
         $display("FAIL first_lookup got hit=%b tk=%b pc=%h exp 1 1 00000080",
                  btbHitF, predictTakenF, predictPcF);
      end
      checks++;
      if (branchCount !== 32'd1 || mispredictCount !== 32'd1) begin
         failures++;
         $display("FAIL first_counts got b=%0d m=%0d exp 1 1", branchCount, mispredictCount);
      end
   endtask

   task automatic test_hysteresis();
      pcF = 32'h0000_0100;
      for (int i = 0; i < 2; i++) begin
         set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080);
         #1;
         checks++;
         if (mispredictE !== 1'b0) begin
            failures++;
            $display("FAIL hyst_taken_%0d got mis=%b exp 0", i, mispredictE);
         end
         tick();
      end
      // ctr now 11: first not-taken drops to 10, still predicting taken.
      set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0080);
      #1;
      checks++;
      if (mispredictE !== 1'b1 || correctPcE !== 32'h0000_0104) begin
         failures++;
         $display("FAIL hyst_nt1_resolve got mis=%b cpc=%h exp 1 00000104", mispredictE, correctPcE);
      end
      tick();
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (btbHitF !== 1'b1 || predictTakenF !== 1'b1 || predictPcF !== 32'h0000_0080) begin
         failures++;
         $display("FAIL hyst_after_nt1 got hit=%b tk=%b pc=%h exp 1 1 00000080",
                  btbHitF, predictTakenF, predictPcF);
      end
      set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0080);
      tick();
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (btbHitF !== 1'b1 || predictTakenF !== 1'b0 || predictPcF !== 32'h0000_0104) begin
         failures++;
         $display("FAIL hyst_after_nt2 got hit=%b tk=%b pc=%h exp 1 0 00000104",
                  btbHitF, predictTakenF, predictPcF);
      end
      checks++;
      if (branchCount !== 32'd5 || mispredictCount !== 32'd3) begin
         failures++;
         $display("FAIL hyst_counts got b=%0d m=%0d exp 5 3", branchCount, mispredictCount);
      end
   endtask

   task automatic test_alias();
      pcF = 32'h0000_0140;
      #1;
      checks++;
      if (btbHitF !== 1'b0 || predictPcF !== 32'h0000_0144) begin
         failures++;
         $display("FAIL alias_miss got hit=%b pc=%h exp 0 00000144", btbHitF, predictPcF);
      end
      set_update(1'b1, 32'h0000_0140, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0144);
      #1;
      checks++;
      if (mispredictE !== 1'b1 || correctPcE !== 32'h0000_0200) begin
         failures++;
         $display("FAIL alias_resolve got mis=%b cpc=%h exp 1 00000200", mispredictE, correctPcE);
      end
      tick();
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (btbHitF !== 1'b1 || predictTakenF !== 1'b1 || predictPcF !== 32'h0000_0200) begin
         failures++;
         $display("FAIL alias_new_hit got hit=%b tk=%b pc=%h exp 1 1 00000200",
                  btbHitF, predictTakenF, predictPcF);
      end
      pcF = 32'h0000_0100;
      #1;
      checks++;
      if (btbHitF !== 1'b0 || predictPcF !== 32'h0000_0104) begin
         failures++;
         $display("FAIL alias_evicted got hit=%b pc=%h exp 0 00000104", btbHitF, predictPcF);
      end
   endtask

   task automatic test_back_to_back();
      pcF = 32'h0000_0100;
      set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b0, 32'h0000_0104);
      #1;
      checks++;
      if (btbHitF !== 1'b0 || mispredictE !== 1'b1) begin
         failures++;
         $display("FAIL same_cycle_alloc got hit=%b mis=%b exp 0 1", btbHitF, mispredictE);
      end
      tick();
      set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080);
      #1;
      checks++;
      if (btbHitF !== 1'b1 || mispredictE !== 1'b0 || branchCount !== 32'd7 || mispredictCount !== 32'd5) begin
         failures++;
         $display("FAIL same_cycle_next got hit=%b mis=%b b=%0d m=%0d exp 1 0 7 5",
                  btbHitF, mispredictE, branchCount, mispredictCount);
      end
      tick();
      // Direction right but target wrong still counts as a mispredict.
      set_update(1'b1, 32'h0000_0100, 32'h0000_0080, 1'b1, 1'b1, 32'h0000_0084);
      #1;
      checks++;
      if (branchCount !== 32'd8 || mispredictCount !== 32'd5 || mispredictE !== 1'b1) begin
         failures++;
         $display("FAIL correct_pred_counts got b=%0d m=%0d mis=%b exp 8 5 1",
                  branchCount, mispredictCount, mispredictE);
      end
      tick();
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      pcF = 32'hFFFF_FFFC;
      #1;
      checks++;
      if (branchCount !== 32'd9 || mispredictCount !== 32'd6 || predictPcF !== 32'h0000_0000) begin
         failures++;
         $display("FAIL wrap_and_counts got b=%0d m=%0d pc=%h exp 9 6 00000000",
                  branchCount, mispredictCount, predictPcF);
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      pcF = 32'h0000_010C;
      set_update(1'b1, 32'h0000_010C, 32'h0000_0300, 1'b1, 1'b0, 32'h0000_0110);
      tick();
      rst = 1'b0;
      set_update(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++;
      if (btbHitF !== 1'b0 || predictPcF !== 32'h0000_0110) begin
         failures++;
         $display("FAIL rst_mid_blocked got hit=%b pc=%h exp 0 00000110", btbHitF, predictPcF);
      end
      pcF = 32'h0000_0100;
      #1;
      checks++;
      if (btbHitF !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_cleared_100 got hit=%b exp 0", btbHitF);
      end
      pcF = 32'h0000_0140;
      #1;
      checks++;
      if (btbHitF !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_cleared_140 got hit=%b exp 0", btbHitF);
      end
      checks++;
      if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid_counts got b=%0d m=%0d exp 0 0", branchCount, mispredictCount);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_first_taken();
      test_hysteresis();
      test_alias();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
